axis_bram_adapter: RTL and testbench

Bridges 32-bit AXI-Stream and a wide single-port BRAM whose line holds WORDS_PER_LINE 32-bit words (1152 bits by default). AXI-Lite registers select the direction and an inclusive line-address window [START, END]. In write mode, stream beats are packed into lines and written to BRAM. In read mode, BRAM lines are unpacked into stream beats.

---
 rtl/axis_bram_adapter.sv | 248 ++++++++++++++++++++++++
 tb/tb_axis_bram_adapter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter.sv
// rtl/axis_bram_adapter.sv - AXI-Stream <-> wide single-port BRAM line packer/unpacker with AXI-Lite control
module axis_bram_adapter #(
  parameter int WORDS_PER_LINE = 36,
  parameter int ADDR_W         = 12,
  parameter int AXIL_ADDR_W    = 5
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [31:0]                    s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [31:0]                    m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           bram_en,
  output logic                           bram_wen,
  output logic [ADDR_W-1:0]              bram_addr,
  output logic [32*WORDS_PER_LINE-1:0]   bram_wdata,
  input  logic [32*WORDS_PER_LINE-1:0]   bram_rdata,
  input  logic [AXIL_ADDR_W-1:0]         s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [31:0]                    s_axi_wdata,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [AXIL_ADDR_W-1:0]         s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [31:0]                    s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready
);

  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int IDX_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  localparam logic [AXIL_ADDR_W-1:0] A_CTRL   = AXIL_ADDR_W'(0);
  localparam logic [AXIL_ADDR_W-1:0] A_START  = AXIL_ADDR_W'(4);
  localparam logic [AXIL_ADDR_W-1:0] A_END    = AXIL_ADDR_W'(8);
  localparam logic [AXIL_ADDR_W-1:0] A_STATUS = AXIL_ADDR_W'(12);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_RD_EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]  start_q, start_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic               wr_pend_q, wr_pend_d;
  logic               wr_final_q, wr_final_d;
  logic               awready_q, awready_d;
  logic               bvalid_q, bvalid_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               start_op;
  logic               busy;
  logic               unused_wdata;

  assign unused_wdata = ^s_axi_wdata[31:ADDR_W];
  assign busy         = (state_q != ST_IDLE);

  // Once the END line is queued for writing no further beats may be taken.
  assign s_axis_tready = (state_q == ST_WRITE) && !(wr_pend_q && wr_final_q);
  assign bram_en       = wr_pend_q || (state_q == ST_RD_ISSUE);
  assign bram_wen      = wr_pend_q;
  assign bram_addr     = ptr_q;
  assign bram_wdata    = wline_q;
  assign m_axis_tdata  = line_q[31:0];
  assign m_axis_tvalid = (state_q == ST_RD_EMIT);
  assign m_axis_tlast  = m_axis_tvalid && (idx_q == LAST_IDX) && (ptr_q == end_q);

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    start_d    = start_q;
    end_d      = end_q;
    done_d     = done_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    line_d     = line_q;
    wline_d    = wline_q;
    wr_pend_d  = wr_pend_q;
    wr_final_d = wr_final_q;
    awready_d  = 1'b0;
    bvalid_d   = bvalid_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    start_op   = 1'b0;

    if (awready_q) begin
      bvalid_d = 1'b1;
      case (s_axi_awaddr)
        A_CTRL: begin
          ctrl_d   = s_axi_wdata[1:0];
          start_op = s_axi_wdata[1] && !ctrl_q[1];
        end
        A_START: start_d = s_axi_wdata[ADDR_W-1:0];
        A_END:   end_d   = s_axi_wdata[ADDR_W-1:0];
        default: ;
      endcase
    end else begin
      awready_d = s_axi_awvalid && s_axi_wvalid && !bvalid_q;
      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    end

    if (arready_q) begin
      rvalid_d = 1'b1;
      case (s_axi_araddr)
        A_CTRL:   rdata_d = {30'd0, ctrl_q};
        A_START:  rdata_d = 32'(start_q);
        A_END:    rdata_d = 32'(end_q);
        A_STATUS: rdata_d = {30'd0, done_q, busy};
        default:  rdata_d = 32'd0;
      endcase
    end else begin
      arready_d = s_axi_arvalid && !rvalid_q;
      if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    end

    case (state_q)
      ST_WRITE: begin
        if (wr_pend_q) begin
          wr_pend_d = 1'b0;
          ptr_d     = ptr_q + 1'b1;
          if (wr_final_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        if (s_axis_tvalid && s_axis_tready) begin
          line_d[{idx_q, 5'd0} +: 32] = s_axis_tdata;
          if (idx_q == LAST_IDX || s_axis_tlast) begin
            // ptr_d already points at the line being completed here.
            wline_d    = line_d;
            line_d     = '0;
            idx_d      = '0;
            wr_pend_d  = 1'b1;
            wr_final_d = (ptr_d == end_q);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        line_d  = bram_rdata;
        idx_d   = '0;
        state_d = ST_RD_EMIT;
      end
      ST_RD_EMIT: begin
        if (m_axis_tready) begin
          line_d = line_q >> 32;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (ptr_q == end_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              ptr_d   = ptr_q + 1'b1;
              state_d = ST_RD_ISSUE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A RELOAD rising edge wins over everything, including a queued write.
    if (start_op) begin
      state_d    = s_axi_wdata[0] ? ST_WRITE : ST_RD_ISSUE;
      ptr_d      = start_q;
      idx_d      = '0;
      line_d     = '0;
      wr_pend_d  = 1'b0;
      wr_final_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      idx_q      <= '0;
      line_q     <= '0;
      wline_q    <= '0;
      wr_pend_q  <= 1'b0;
      wr_final_q <= 1'b0;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      start_q    <= start_d;
      end_q      <= end_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      line_q     <= line_d;
      wline_q    <= wline_d;
      wr_pend_q  <= wr_pend_d;
      wr_final_q <= wr_final_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axis_bram_adapter.sv
// tb/tb_axis_bram_adapter.sv - directed self-checking bench for axis_bram_adapter
module tb_axis_bram_adapter;
  localparam int WPL    = 36;
  localparam int LINE_W = 32 * WPL;
  localparam int ADDR_W = 12;
  localparam int AW     = 5;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [31:0]       s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic              bram_en;
  logic              bram_wen;
  logic [ADDR_W-1:0] bram_addr;
  logic [LINE_W-1:0] bram_wdata;
  logic [LINE_W-1:0] bram_rdata = '0;
  logic [AW-1:0]     s_axi_awaddr = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [AW-1:0]     s_axi_araddr = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axis_bram_adapter #(.WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W), .AXIL_ADDR_W(AW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  // BRAM model: one-cycle read latency, write log for checking
  logic [LINE_W-1:0] mem [0:7];
  logic [ADDR_W-1:0] wr_addr_log [0:7];
  int wr_count = 0;

  always @(posedge aclk) begin
    if (bram_en && bram_wen) begin
      mem[bram_addr[2:0]]         <= bram_wdata;
      wr_addr_log[wr_count[2:0]]  <= bram_addr;
      wr_count                    <= wr_count + 1;
    end else if (bram_en) begin
      bram_rdata <= mem[bram_addr[2:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int n);
    int k;
    logic [31:0] w;
    k = n % WPL;
    if (k == 0)            w = 32'hbbbbbbbb;
    else if (k == WPL - 1) w = 32'heeeeeeee;
    else if (k % 2 == 1)   w = 32'hdddddddd;
    else                   w = 32'hffffffff;
    if (n >= WPL) w = w ^ 32'h01010101;
    return w;
  endfunction

  task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data, input int bdly);
    int t;
    @(posedge aclk); #1;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata  = data; s_axi_wvalid  = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_awready && t < 20);
    check("awready", {31'd0, s_axi_awready && s_axi_wready}, 32'd1);
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge aclk);
    check("bvalid", {31'd0, s_axi_bvalid}, 32'd1);
    repeat (bdly) begin
      @(negedge aclk);
      check("bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
    end
    @(posedge aclk); #1; s_axi_bready = 1'b1;
    @(posedge aclk); #1; s_axi_bready = 1'b0;
    if (bdly > 0) begin
      @(negedge aclk);
      check("bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
      @(posedge aclk); #1;
    end
  endtask

  task automatic axil_read(input logic [AW-1:0] addr, output logic [31:0] data, input int rdly);
    int t;
    @(posedge aclk); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_arready && t < 20);
    check("arready", {31'd0, s_axi_arready}, 32'd1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge aclk);
    check("rvalid", {31'd0, s_axi_rvalid}, 32'd1);
    data = s_axi_rdata;
    repeat (rdly) begin
      @(negedge aclk);
      check("rvalid_hold", {31'd0, s_axi_rvalid}, 32'd1);
      check("rdata_hold", s_axi_rdata, data);
    end
    @(posedge aclk); #1; s_axi_rready = 1'b1;
    @(posedge aclk); #1; s_axi_rready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int t;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axis_tready && t < 50);
    check("s_tready", {31'd0, s_axis_tready}, 32'd1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic recv_lines(input bit toggle);
    int n;
    int t;
    logic stalled;
    logic [31:0] held;
    n = 0; t = 0; stalled = 1'b0; held = '0;
    while (n < 2 * WPL && t < 2000) begin
      @(posedge aclk); #1;
      m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
      @(negedge aclk);
      t++;
      if (stalled) begin
        check("m_hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("m_hold_data", m_axis_tdata, held);
      end
      stalled = 1'b0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          check("m_tdata", m_axis_tdata, pat(n));
          check("m_tlast", {31'd0, m_axis_tlast}, {31'd0, n == 2 * WPL - 1});
          n++;
        end else begin
          stalled = 1'b1;
          held    = m_axis_tdata;
        end
      end
    end
    check("m_beats", n, 2 * WPL);
    @(posedge aclk); #1;
    m_axis_tready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int nz;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_stream", {28'd0, s_axis_tready, m_axis_tvalid, m_axis_tlast, 1'b0}, 32'd0);
    check("rst_mtdata", m_axis_tdata, 32'd0);
    check("rst_bram", {19'd0, bram_en, bram_wen, 11'd0} | 32'(bram_addr), 32'd0);
    check("rst_wdata", bram_wdata[31:0] | bram_wdata[LINE_W-1:LINE_W-32], 32'd0);
    check("rst_axil", {28'd0, s_axi_awready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;

    axil_read(5'h00, rd, 0); check("rst_ctrl", rd, 32'd0);
    axil_read(5'h04, rd, 0); check("rst_start", rd, 32'd0);
    axil_read(5'h08, rd, 0); check("rst_end", rd, 32'd0);
    axil_read(5'h0C, rd, 0); check("rst_status", rd, 32'd0);

    axil_write(5'h04, 32'd5, 3);
    axil_read(5'h04, rd, 3); check("start_rb", rd, 32'd5);
    axil_write(5'h10, 32'hffffffff, 0);
    axil_read(5'h10, rd, 0); check("unmapped_rd", rd, 32'd0);
    axil_read(5'h04, rd, 0); check("start_keep", rd, 32'd5);

    // Write mode, two full lines into addresses 0 and 1
    axil_write(5'h04, 32'd0, 0);
    axil_write(5'h08, 32'd1, 0);
    axil_write(5'h00, 32'd1, 0);
    axil_write(5'h00, 32'd3, 0);
    axil_write(5'h00, 32'd1, 0);
    for (int n = 0; n < 2 * WPL; n++) send_beat(pat(n), 1'b0);
    s_axis_tdata = 32'hdeadbeef; s_axis_tvalid = 1'b1;
    repeat (4) @(negedge aclk);
    check("wr_tready_off", {31'd0, s_axis_tready}, 32'd0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    check("wr_count", wr_count, 32'd2);
    check("wr_addr0", 32'(wr_addr_log[0]), 32'd0);
    check("wr_addr1", 32'(wr_addr_log[1]), 32'd1);
    check("line0_w0", mem[0][31:0], 32'hbbbbbbbb);
    check("line0_w35", mem[0][1151:1120], 32'heeeeeeee);
    check("line1_w1", mem[1][63:32], pat(WPL + 1));
    axil_read(5'h0C, rd, 0); check("wr_status", rd, 32'd2);

    // Read mode, continuous ready
    axil_write(5'h00, 32'd2, 0);
    axil_write(5'h00, 32'd0, 0);
    recv_lines(1'b0);
    repeat (2) @(negedge aclk);
    check("rd_tvalid_off", {31'd0, m_axis_tvalid}, 32'd0);
    axil_read(5'h0C, rd, 0); check("rd_status", rd, 32'd2);

    // Read mode, ready toggling every cycle
    axil_write(5'h00, 32'd2, 0);
    axil_write(5'h00, 32'd0, 0);
    recv_lines(1'b1);
    axil_read(5'h0C, rd, 0); check("rdt_status", rd, 32'd2);

    // Write mode, tlast on the 10th word flushes a partial line into address 3
    axil_write(5'h04, 32'd3, 0);
    axil_write(5'h08, 32'd3, 0);
    axil_write(5'h00, 32'd1, 0);
    axil_write(5'h00, 32'd3, 0);
    for (int k = 0; k < 10; k++) send_beat(32'h30000000 + k, k == 9);
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("tl_count", wr_count, 32'd3);
    check("tl_addr", 32'(wr_addr_log[2]), 32'd3);
    check("tl_w0", mem[3][31:0], 32'h30000000);
    check("tl_w9", mem[3][319:288], 32'h30000009);
    nz = 0;
    for (int k = 10; k < WPL; k++) if (mem[3][32*k +: 32] !== 32'd0) nz++;
    check("tl_zero_tail", nz, 32'd0);
    check("tl_tready_off", {31'd0, s_axis_tready}, 32'd0);
    axil_read(5'h0C, rd, 0); check("tl_status", rd, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
